// File: rtl/ysyx_25040111_axi_sram.sv
// ysyx_25040111_axi_sram: AXI4 slave main memory for the npc (used when RUNSOC is not defined).
// Serves INCR read bursts (icache refills) and single/multi-beat writes from a
// single-port word-addressed array; reads and writes are serialized by one FSM.
// Optional feature macro: AXI_SRAM_DELAY_EN. When defined, every R beat and B
// response waits DELAY cycles; when undefined the wait is always zero cycles.
module ysyx_25040111_axi_sram #(
    parameter int          ADDR_W = 16,
    parameter logic [31:0] BASE   = 32'h8000_0000,
    parameter int          DELAY  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic [3:0]  s_awid,
    input  logic [7:0]  s_awlen,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wlast,
    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [1:0]  s_bresp,
    output logic [3:0]  s_bid,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    input  logic [3:0]  s_arid,
    input  logic [7:0]  s_arlen,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rlast,
    output logic [3:0]  s_rid
);

    localparam int DEPTH = 1 << ADDR_W;

`ifdef AXI_SRAM_DELAY_EN
    localparam bit DelayEn = 1'b1;
`else
    localparam bit DelayEn = 1'b0;
`endif
    localparam int          Dly    = DelayEn ? DELAY : 0;
    localparam logic [7:0]  DlyCnt = 8'(Dly);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic       PRI_RD      = 1'b0;
    localparam logic       PRI_WR      = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        WRESP
    } state_t;

    state_t      state_q;
    logic        rrPri_q;
    logic [31:0] burstAddr_q;
    logic [7:0]  len_q;
    logic [7:0]  beat_q;
    logic [7:0]  wait_q;
    logic        berr_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        rlast_q;
    logic [3:0]  rid_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic [3:0]  bid_q;

    logic [31:0] mem [DEPTH];

    logic        arHs;
    logic        awHs;
    logic        rAccept;
    logic        wFire;
    logic [31:0] rdAddr_d;
    logic        rdOk;
    logic [31:0] rdWord;
    logic [7:0]  beatNext;
    logic        wrOk;
    logic        wrLenEnd;
    logic        wrEnd;
    logic        berr_d;

    // Byte address lies inside BASE .. BASE+4*DEPTH-1 (wider compare avoids overflow)
    function automatic logic inWindow(input logic [31:0] a);
        return {32'h0, a - BASE} < (64'd4 << ADDR_W);
    endfunction

    // Word index of a byte address, wrapping modulo DEPTH; low two bits dropped
    function automatic logic [ADDR_W-1:0] wordIdx(input logic [31:0] a);
        return ADDR_W'((a - BASE) >> 2);
    endfunction

    // Address arbitration is only open in IDLE; contention is settled by the round-robin pointer
    assign arHs = reset && (state_q == IDLE) && s_arvalid && (!s_awvalid || rrPri_q == PRI_RD);
    assign awHs = reset && (state_q == IDLE) && s_awvalid && (!s_arvalid || rrPri_q == PRI_WR);

    assign s_arready = arHs;
    assign s_awready = awHs;
    assign s_wready  = (state_q == WR);
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign s_rlast   = rlast_q;
    assign s_rid     = rid_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_bid     = bid_q;

    assign rAccept  = (state_q == RD) && rvalid_q && s_rready;
    assign wFire    = (state_q == WR) && s_wvalid;
    assign beatNext = beat_q + 8'd1;
    assign wrOk     = inWindow(burstAddr_q);
    assign wrLenEnd = (beat_q == len_q);
    assign wrEnd    = s_wlast || wrLenEnd;
    assign berr_d   = berr_q || !wrOk || (s_wlast != wrLenEnd);

    // Pick the address of the beat about to be loaded: new burst, next beat, or a delayed beat
    always_comb begin
        rdAddr_d = burstAddr_q;
        if (state_q == IDLE) begin
            rdAddr_d = s_araddr;
        end else if (rAccept) begin
            rdAddr_d = burstAddr_q + 32'd4;
        end
    end

    assign rdOk   = inWindow(rdAddr_d);
    assign rdWord = mem[wordIdx(rdAddr_d)];

    // Byte-lane writes into the array; out-of-window beats are dropped
    always_ff @(posedge clock) begin
        if (wFire && wrOk) begin
            for (int b = 0; b < 4; b++) begin
                if (s_wstrb[b]) begin
                    mem[wordIdx(burstAddr_q)][8*b +: 8] <= s_wdata[8*b +: 8];
                end
            end
        end
    end

    // Main FSM: arbitration, burst tracking, wait countdown and registered R/B channel outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rrPri_q     <= PRI_RD;
            burstAddr_q <= 32'h0;
            len_q       <= 8'h0;
            beat_q      <= 8'h0;
            wait_q      <= 8'h0;
            berr_q      <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'h0;
            rresp_q     <= RESP_OKAY;
            rlast_q     <= 1'b0;
            rid_q       <= 4'h0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            bid_q       <= 4'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_arvalid && s_awvalid) begin
                        rrPri_q <= ~rrPri_q;
                    end
                    if (arHs) begin
                        burstAddr_q <= s_araddr;
                        len_q       <= s_arlen;
                        rid_q       <= s_arid;
                        beat_q      <= 8'h0;
                        state_q     <= RD;
                        if (DlyCnt == 8'd0) begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= rdOk ? rdWord : 32'h0;
                            rresp_q  <= rdOk ? RESP_OKAY : RESP_SLVERR;
                            rlast_q  <= (s_arlen == 8'd0);
                        end else begin
                            wait_q <= DlyCnt;
                        end
                    end else if (awHs) begin
                        burstAddr_q <= s_awaddr;
                        len_q       <= s_awlen;
                        bid_q       <= s_awid;
                        beat_q      <= 8'h0;
                        berr_q      <= 1'b0;
                        state_q     <= WR;
                    end
                end
                RD: begin
                    if (rAccept) begin
                        if (rlast_q) begin
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            burstAddr_q <= burstAddr_q + 32'd4;
                            beat_q      <= beatNext;
                            if (DlyCnt == 8'd0) begin
                                rvalid_q <= 1'b1;
                                rdata_q  <= rdOk ? rdWord : 32'h0;
                                rresp_q  <= rdOk ? RESP_OKAY : RESP_SLVERR;
                                rlast_q  <= (beatNext == len_q);
                            end else begin
                                rvalid_q <= 1'b0;
                                wait_q   <= DlyCnt;
                            end
                        end
                    end else if (!rvalid_q) begin
                        if (wait_q <= 8'd1) begin
                            wait_q   <= 8'h0;
                            rvalid_q <= 1'b1;
                            rdata_q  <= rdOk ? rdWord : 32'h0;
                            rresp_q  <= rdOk ? RESP_OKAY : RESP_SLVERR;
                            rlast_q  <= (beat_q == len_q);
                        end else begin
                            wait_q <= wait_q - 8'd1;
                        end
                    end
                end
                WR: begin
                    if (wFire) begin
                        burstAddr_q <= burstAddr_q + 32'd4;
                        beat_q      <= beatNext;
                        berr_q      <= berr_d;
                        if (wrEnd) begin
                            state_q <= WRESP;
                            if (DlyCnt == 8'd0) begin
                                bvalid_q <= 1'b1;
                                bresp_q  <= berr_d ? RESP_SLVERR : RESP_OKAY;
                            end else begin
                                wait_q <= DlyCnt;
                            end
                        end
                    end
                end
                WRESP: begin
                    if (bvalid_q) begin
                        if (s_bready) begin
                            bvalid_q <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end else if (wait_q <= 8'd1) begin
                        wait_q   <= 8'h0;
                        bvalid_q <= 1'b1;
                        bresp_q  <= berr_q ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        wait_q <= wait_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
